// File: rtl/load_store_unit_if.sv
// load_store_unit_if: datapath request/response and data-memory port bundle
interface load_store_unit_if #(parameter int DATA_WIDTH = 32);
  logic                  req_valid;
  logic                  req_ready;
  logic                  req_write;
  logic [1:0]            req_size;
  logic                  req_unsigned;
  logic [DATA_WIDTH-1:0] req_addr;
  logic [DATA_WIDTH-1:0] req_wdata;
  logic                  resp_valid;
  logic [DATA_WIDTH-1:0] resp_rdata;
  logic                  resp_error;
  logic [DATA_WIDTH-1:0] mem_address;
  logic [DATA_WIDTH-1:0] mem_write_data;
  logic                  mem_write;
  logic                  mem_read;
  logic [DATA_WIDTH-1:0] mem_read_data;
  modport slave (
    input  req_valid, req_write, req_size, req_unsigned, req_addr, req_wdata, mem_read_data,
    output req_ready, resp_valid, resp_rdata, resp_error, mem_address, mem_write_data, mem_write, mem_read
  );
  modport master (
    output req_valid, req_write, req_size, req_unsigned, req_addr, req_wdata, mem_read_data,
    input  req_ready, resp_valid, resp_rdata, resp_error, mem_address, mem_write_data, mem_write, mem_read
  );
endinterface

// File: rtl/load_store_unit.sv
// load_store_unit: byte/half/word loads and stores over a word-addressed memory, sub-word stores by read-modify-write
module load_store_unit #(parameter int DATA_WIDTH = 32) (
  input logic clk,
  input logic reset,
  load_store_unit_if.slave bus
);
  typedef enum logic [1:0] {IDLE, READ, WRITE, RESP} lsuState;
  lsuState state, nextState;
  logic [DATA_WIDTH-1:0] addrReg, wdataReg, mergeReg, rdataReg;
  logic [DATA_WIDTH-1:0] loadData, mergeData, laneMask, laneData;
  logic [1:0] sizeReg;
  logic unsReg, writeReg, errorReg, accept, misaligned;
  logic [7:0] byteSel;
  logic [15:0] halfSel;
  assign accept = state == IDLE && bus.req_valid;
  assign misaligned = bus.req_size == 2'b11 || (bus.req_size == 2'b01 && bus.req_addr[0]) ||
                      (bus.req_size == 2'b10 && bus.req_addr[1:0] != 2'b00);
  // state register; reset aborts any request in flight
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else state <= nextState;
  end
  // next state: word stores skip the read, sub-word stores read then write
  always_comb begin
    nextState = state;
    unique case (state)
      IDLE:  if (accept) nextState = misaligned ? RESP : (bus.req_write && bus.req_size == 2'b10) ? WRITE : READ;
      READ:  nextState = writeReg ? WRITE : RESP;
      WRITE: nextState = RESP;
      RESP:  nextState = IDLE;
    endcase
  end
  // outputs; memory strobes are gated by reset so an aborted store never writes
  always_comb begin
    bus.req_ready = state == IDLE;
    bus.resp_valid = state == RESP;
    bus.resp_rdata = rdataReg;
    bus.resp_error = errorReg;
    bus.mem_read = !reset && state == READ;
    bus.mem_write = !reset && state == WRITE;
    bus.mem_write_data = state == WRITE ? (sizeReg == 2'b10 ? wdataReg : mergeReg) : '0;
    bus.mem_address = {addrReg[DATA_WIDTH-1:2], 2'b00};
  end
  // lane extraction for loads and lane merge for sub-word stores
  always_comb begin
    byteSel = bus.mem_read_data[{addrReg[1:0], 3'b000} +: 8];
    halfSel = bus.mem_read_data[{addrReg[1], 4'b0000} +: 16];
    loadData = sizeReg == 2'b00 ? {{24{~unsReg & byteSel[7]}}, byteSel} :
               sizeReg == 2'b01 ? {{16{~unsReg & halfSel[15]}}, halfSel} : bus.mem_read_data;
    laneMask = sizeReg == 2'b00 ? 32'h0000_00FF << {addrReg[1:0], 3'b000} : 32'h0000_FFFF << {addrReg[1], 4'b0000};
    laneData = sizeReg == 2'b00 ? {4{wdataReg[7:0]}} : {2{wdataReg[15:0]}};
    mergeData = (bus.mem_read_data & ~laneMask) | (laneData & laneMask);
  end
  // request latch, RMW merge word and response registers held until the next response
  always_ff @(posedge clk) begin
    if (reset) begin
      addrReg <= '0;
      wdataReg <= '0;
      sizeReg <= '0;
      unsReg <= 1'b0;
      writeReg <= 1'b0;
      mergeReg <= '0;
      rdataReg <= '0;
      errorReg <= 1'b0;
    end else begin
      if (accept) begin
        addrReg <= bus.req_addr;
        wdataReg <= bus.req_wdata;
        sizeReg <= bus.req_size;
        unsReg <= bus.req_unsigned;
        writeReg <= bus.req_write;
        if (misaligned) begin
          rdataReg <= '0;
          errorReg <= 1'b1;
        end
      end
      if (state == READ && !writeReg) begin
        rdataReg <= loadData;
        errorReg <= 1'b0;
      end
      if (state == READ && writeReg) mergeReg <= mergeData;
      if (state == WRITE) begin
        rdataReg <= '0;
        errorReg <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit: random and directed requests scored against a byte-lane memory model
module tb_load_store_unit;
  typedef struct {int acc; int lat; logic [31:0] rdata; logic err; logic rd;} resp_t;
  typedef struct {int acc; int lat; logic [31:0] addr; logic [31:0] data;} wr_t;
  logic clk = 0;
  logic reset = 1;
  logic initMem = 1;
  int cyc = 0;
  int compared = 0;
  int mismatched = 0;
  logic [31:0] mem [16];
  logic [31:0] refMem [16];
  logic [31:0] lastRdata;
  logic lastErr;
  resp_t rq [$];
  wr_t wq [$];
  load_store_unit_if #(.DATA_WIDTH(32)) bus();
  load_store_unit #(.DATA_WIDTH(32)) dut (.clk(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  function automatic logic [31:0] pat(input int i);
    return 32'(i) * 32'h0123_4567 ^ 32'hA5A5_F00F;
  endfunction
  always @(posedge clk) begin
    if (initMem) for (int i = 0; i < 16; i++) mem[i] <= pat(i);
    else if (bus.mem_write) mem[bus.mem_address[5:2]] <= bus.mem_write_data;
  end
  assign bus.mem_read_data = mem[bus.mem_address[5:2]];
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  always @(negedge clk) begin
    if (initMem) for (int i = 0; i < 16; i++) refMem[i] = pat(i);
    else if (!reset) begin
      if (bus.mem_read) begin
        if (rq.size() == 0) check("mem_read_unexpected", 1, 0);
        else begin
          check("mem_read_allowed", 32'(rq[0].rd), 1);
          check("mem_read_cycle", 32'(cyc - rq[0].acc), 0);
        end
      end
      if (bus.mem_write) begin
        if (wq.size() == 0) check("mem_write_unexpected", 1, 0);
        else begin
          check("write_addr", bus.mem_address, wq[0].addr);
          check("write_data", bus.mem_write_data, wq[0].data);
          check("write_cycle", 32'(cyc - wq[0].acc), 32'(wq[0].lat));
          refMem[wq[0].addr[5:2]] = wq[0].data;
          void'(wq.pop_front());
        end
      end
      if (bus.resp_valid) begin
        if (rq.size() == 0) check("resp_unexpected", 1, 0);
        else begin
          check("resp_rdata", bus.resp_rdata, rq[0].rdata);
          check("resp_error", 32'(bus.resp_error), 32'(rq[0].err));
          check("resp_cycle", 32'(cyc - rq[0].acc), 32'(rq[0].lat));
          void'(rq.pop_front());
        end
        lastRdata = bus.resp_rdata;
        lastErr = bus.resp_error;
      end else if (rq.size() != 0 && cyc - rq[0].acc > rq[0].lat) begin
        check("resp_timeout", 0, 1);
        void'(rq.pop_front());
      end
    end
  end
  task automatic issue(input logic wr, input logic [1:0] sz, input logic un, input logic [31:0] a, input logic [31:0] wd);
    int w = 0;
    int nb;
    int off;
    logic err;
    logic [31:0] word;
    logic [31:0] v;
    @(negedge clk);
    while (!bus.req_ready && w < 20) begin
      bus.req_valid = 1'($urandom % 2);
      bus.req_write = 1'($urandom % 2);
      bus.req_size = 2'($urandom % 4);
      bus.req_unsigned = 1'($urandom % 2);
      bus.req_addr = 32'h1001_0000 + ($urandom % 64);
      bus.req_wdata = $urandom;
      @(negedge clk);
      w++;
    end
    if (!bus.req_ready) begin
      bus.req_valid = 0;
      check("ready_timeout", 0, 1);
      return;
    end
    bus.req_valid = 1;
    bus.req_write = wr;
    bus.req_size = sz;
    bus.req_unsigned = un;
    bus.req_addr = a;
    bus.req_wdata = wd;
    err = sz == 3 || (sz == 1 && a[0]) || (sz == 2 && a[1:0] != 0);
    nb = sz == 0 ? 1 : sz == 1 ? 2 : 4;
    off = int'(a[1:0]);
    word = refMem[a[5:2]];
    if (err) rq.push_back('{cyc + 1, 0, 32'h0, 1'b1, 1'b0});
    else if (!wr) begin
      v = 0;
      for (int i = 0; i < nb; i++) v |= ((word >> (8 * (off + i))) & 32'hFF) << (8 * i);
      if (!un && nb < 4 && v[8 * nb - 1]) v |= 32'hFFFF_FFFF << (8 * nb);
      rq.push_back('{cyc + 1, 1, v, 1'b0, 1'b1});
    end else begin
      for (int i = 0; i < nb; i++)
        word = (word & ~(32'hFF << (8 * (off + i)))) | (((wd >> (8 * i)) & 32'hFF) << (8 * (off + i)));
      wq.push_back('{cyc + 1, nb == 4 ? 0 : 1, {a[31:2], 2'b00}, word});
      rq.push_back('{cyc + 1, nb == 4 ? 1 : 2, 32'h0, 1'b0, nb != 4});
    end
    @(posedge clk);
    #1 bus.req_valid = 0;
  endtask
  task automatic wait_idle();
    int w = 0;
    while (rq.size() != 0 && w < 30) begin
      @(negedge clk);
      w++;
    end
    check("drain", 32'(rq.size() + wq.size()), 0);
  endtask
  task automatic expect_resp(input string name, input logic [31:0] rdata, input logic err);
    wait_idle();
    check(name, lastRdata, rdata);
    check({name, "_err"}, 32'(lastErr), 32'(err));
  endtask
  initial begin
    bus.req_valid = 0;
    bus.req_write = 0;
    bus.req_size = 0;
    bus.req_unsigned = 0;
    bus.req_addr = 0;
    bus.req_wdata = 0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_ready", 32'(bus.req_ready), 1);
    check("rst_resp_valid", 32'(bus.resp_valid), 0);
    check("rst_resp_error", 32'(bus.resp_error), 0);
    check("rst_resp_rdata", bus.resp_rdata, 0);
    check("rst_mem_read", 32'(bus.mem_read), 0);
    check("rst_mem_write", 32'(bus.mem_write), 0);
    initMem = 0;
    reset = 0;
    issue(1, 2, 0, 32'h1001_0004, 32'hDEAD_BEEF);
    expect_resp("sw", 32'h0, 0);
    check("sw_mem", mem[1], 32'hDEAD_BEEF);
    issue(1, 2, 0, 32'h1001_0008, 32'h80F1_7F01);
    wait_idle();
    issue(0, 0, 0, 32'h1001_0009, 0); expect_resp("lb1", 32'h0000_007F, 0);
    issue(0, 0, 0, 32'h1001_000A, 0); expect_resp("lb2", 32'hFFFF_FFF1, 0);
    issue(0, 0, 1, 32'h1001_000B, 0); expect_resp("lbu3", 32'h0000_0080, 0);
    issue(0, 1, 0, 32'h1001_000A, 0); expect_resp("lh2", 32'hFFFF_80F1, 0);
    issue(0, 1, 1, 32'h1001_000A, 0); expect_resp("lhu2", 32'h0000_80F1, 0);
    issue(0, 2, 0, 32'h1001_0008, 0); expect_resp("lw", 32'h80F1_7F01, 0);
    issue(1, 2, 0, 32'h1001_0008, 32'h1122_3344);
    issue(1, 0, 0, 32'h1001_0009, 32'hFFFF_FFAA); expect_resp("sb", 32'h0, 0);
    check("sb_mem", mem[2], 32'h1122_AA44);
    issue(1, 2, 0, 32'h1001_0008, 32'h1122_3344);
    issue(1, 1, 0, 32'h1001_000A, 32'h0000_5566); expect_resp("sh", 32'h0, 0);
    check("sh_mem", mem[2], 32'h5566_3344);
    issue(0, 2, 0, 32'h1001_0002, 0); expect_resp("lw_misaligned", 32'h0, 1);
    issue(0, 1, 0, 32'h1001_0001, 0); expect_resp("lh_misaligned", 32'h0, 1);
    issue(0, 3, 0, 32'h1001_0000, 0); expect_resp("size_reserved", 32'h0, 1);
    issue(1, 0, 0, 32'h1001_0009, 32'h0000_00BB);
    #1 reset = 1;
    #1;
    check("abort_mem_read", 32'(bus.mem_read), 0);
    check("abort_mem_write", 32'(bus.mem_write), 0);
    @(posedge clk);
    #1;
    check("abort_ready", 32'(bus.req_ready), 1);
    check("abort_resp_valid", 32'(bus.resp_valid), 0);
    rq.delete();
    wq.delete();
    reset = 0;
    repeat (3) begin
      @(negedge clk);
      check("abort_no_resp", 32'(bus.resp_valid), 0);
    end
    check("abort_mem", mem[2], 32'h5566_3344);
    for (int n = 0; n < 300; n++) begin
      repeat ($urandom % 3) @(negedge clk);
      issue(1'($urandom % 2), 2'($urandom % 4), 1'($urandom % 2), 32'h1001_0000 + ($urandom % 64), $urandom);
    end
    wait_idle();
    for (int i = 0; i < 16; i++) check("final_mem", mem[i], refMem[i]);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
